// File: rtl/rgbw_frame_dispenser.sv
// rgbw_frame_dispenser
// Assembles framed SPI byte streams into a double-buffered bank of NUM_CH
// channel values plus a mode byte. The frame layout is SYNC_BYTE, MODE,
// NUM_CH*BPC data bytes (channel 0 first, each channel MSB first) and, when
// FRAME_CHECKSUM_EN is defined, a trailing XOR checksum over MODE and data.
// Incoming bytes land in shadow registers. The visible outputs change only
// when a complete, valid frame commits, and they change all at once.
// Build option: `define FRAME_CHECKSUM_EN to add the CSUM state and XOR check.
module rgbw_frame_dispenser #(
  parameter int         NUM_CH    = 4,
  parameter int         DATA_W    = 8,
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = $clog2(NUM_CH * (DATA_W / 8) + 3)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               rx_byte,
  input  logic                     rx_rdy,
  input  logic                     cs_n,
  output logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [7:0]               mode,
  output logic                     frame_valid,
  output logic                     frame_err,
  output logic                     busy,
  output logic [CNT_W-1:0]         byte_cnt
);

  localparam int BPC    = DATA_W / 8;
  localparam int NBYTES = NUM_CH * BPC;

  // byte_cnt value while the final data byte is expected (SYNC + MODE + data-1)
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES + 1);

`ifdef FRAME_CHECKSUM_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MODE, ST_DATA, ST_CSUM} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_MODE, ST_DATA} state_t;
`endif

  state_t                  state;
  logic [NBYTES*8-1:0]     shadow_data;   // byte i of the frame payload at bits [i*8 +: 8]
  logic [7:0]              shadow_mode;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]              csum_acc;      // running XOR over MODE and data bytes
`endif

  logic [CNT_W-1:0]        wr_idx;
  logic                    last_byte;
  logic [NBYTES*8-1:0]     byte_img;
  logic [NUM_CH*DATA_W-1:0] commit_data;

  // Payload byte index for the byte currently arriving in DATA.
  assign wr_idx = byte_cnt - CNT_W'(2);

  // The final data byte arrives in the same cycle as the commit. Flag it so
  // that it can bypass the shadow register.
  assign last_byte = (state == ST_DATA) && rx_rdy && !cs_n && (byte_cnt == LAST_CNT);

  // Build the committed channel image from the shadow bytes. The last byte is
  // taken straight from rx_byte when it is arriving this cycle. Each channel
  // is assembled MSB first, and channel 0 sits in the LSBs.
  always_comb begin
    byte_img = shadow_data;
    if (last_byte) begin
      byte_img[(NBYTES-1)*8 +: 8] = rx_byte;
    end
    commit_data = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      for (int j = 0; j < BPC; j++) begin
        commit_data[c*DATA_W + (BPC-1-j)*8 +: 8] = byte_img[(c*BPC + j)*8 +: 8];
      end
    end
  end

  // Frame FSM: shadow capture, abort handling, and registered commit and error outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      ch_data     <= '0;
      mode        <= '0;
      shadow_data <= '0;
      shadow_mode <= '0;
`ifdef FRAME_CHECKSUM_EN
      csum_acc    <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (cs_n) begin
        // Chip select released: drop any partial frame. An idle bus is ignored.
        if (state != ST_IDLE) begin
          state     <= ST_IDLE;
          byte_cnt  <= '0;
          busy      <= 1'b0;
          frame_err <= 1'b1;
        end
      end else if (rx_rdy) begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == SYNC_BYTE) begin
              state    <= ST_MODE;
              byte_cnt <= CNT_W'(1);
              busy     <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          ST_MODE: begin
            shadow_mode <= rx_byte;
`ifdef FRAME_CHECKSUM_EN
            csum_acc    <= rx_byte;
`endif
            state       <= ST_DATA;
            byte_cnt    <= CNT_W'(2);
          end
          ST_DATA: begin
            for (int i = 0; i < NBYTES; i++) begin
              if (wr_idx == CNT_W'(i)) begin
                shadow_data[i*8 +: 8] <= rx_byte;
              end
            end
`ifdef FRAME_CHECKSUM_EN
            csum_acc <= csum_acc ^ rx_byte;
`endif
            if (byte_cnt == LAST_CNT) begin
`ifdef FRAME_CHECKSUM_EN
              state    <= ST_CSUM;
              byte_cnt <= byte_cnt + CNT_W'(1);
`else
              ch_data     <= commit_data;
              mode        <= shadow_mode;
              frame_valid <= 1'b1;
              state       <= ST_IDLE;
              byte_cnt    <= '0;
              busy        <= 1'b0;
`endif
            end else begin
              byte_cnt <= byte_cnt + CNT_W'(1);
            end
          end
`ifdef FRAME_CHECKSUM_EN
          ST_CSUM: begin
            if (rx_byte == csum_acc) begin
              ch_data     <= commit_data;
              mode        <= shadow_mode;
              frame_valid <= 1'b1;
            end else begin
              frame_err   <= 1'b1;
            end
            state    <= ST_IDLE;
            byte_cnt <= '0;
            busy     <= 1'b0;
          end
`endif
          default: begin
            state    <= ST_IDLE;
            byte_cnt <= '0;
            busy     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rgbw_frame_dispenser.sv
// Testbench for rgbw_frame_dispenser.
// Instance dut uses NUM_CH=4 and DATA_W=8 and is driven from a vector table.
// Instance dut_b uses NUM_CH=2 and DATA_W=16 and is driven by a hand-written
// sequence. The expected values follow whichever FRAME_CHECKSUM_EN build is
// compiled.
module tb_rgbw_frame_dispenser;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut: 4 x 8-bit channels
  logic        reset, rx_rdy, cs_n;
  logic [7:0]  rx_byte;
  logic [31:0] ch_data;
  logic [7:0]  mode;
  logic        frame_valid, frame_err, busy;
  logic [2:0]  byte_cnt;

  rgbw_frame_dispenser #(.NUM_CH(4), .DATA_W(8), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .reset(reset), .rx_byte(rx_byte), .rx_rdy(rx_rdy), .cs_n(cs_n),
    .ch_data(ch_data), .mode(mode), .frame_valid(frame_valid),
    .frame_err(frame_err), .busy(busy), .byte_cnt(byte_cnt));

  // dut_b: 2 x 16-bit channels
  logic        reset_b, rx_rdy_b, cs_n_b;
  logic [7:0]  rx_byte_b;
  logic [31:0] ch_data_b;
  logic [7:0]  mode_b;
  logic        frame_valid_b, frame_err_b, busy_b;
  logic [2:0]  byte_cnt_b;

  rgbw_frame_dispenser #(.NUM_CH(2), .DATA_W(16), .SYNC_BYTE(8'hA5)) dut_b (
    .clk(clk), .reset(reset_b), .rx_byte(rx_byte_b), .rx_rdy(rx_rdy_b), .cs_n(cs_n_b),
    .ch_data(ch_data_b), .mode(mode_b), .frame_valid(frame_valid_b),
    .frame_err(frame_err_b), .busy(busy_b), .byte_cnt(byte_cnt_b));

  typedef struct {
    logic        rst;
    logic        cs;
    logic        rdy;
    logic [7:0]  b;
    logic [31:0] cd;
    logic [7:0]  m;
    logic        fv;
    logic        fe;
    logic        bz;
    logic [2:0]  cnt;
  } vec_t;

  vec_t        vq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] cur_cd = '0;
  logic [7:0]  cur_m  = '0;

  task automatic push(input logic r, input logic c, input logic v, input logic [7:0] b,
                      input logic [31:0] cd, input logic [7:0] m,
                      input logic fv, input logic fe, input logic bz, input logic [2:0] cnt);
    vec_t e;
    e.rst = r; e.cs = c; e.rdy = v; e.b = b;
    e.cd = cd; e.m = m; e.fv = fv; e.fe = fe; e.bz = bz; e.cnt = cnt;
    vq.push_back(e);
  endtask

  // Full frame with cs_n low. When good=0 the checksum byte is corrupted.
  task automatic frame(input logic [7:0] md, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3, input logic good);
    push(0, 0, 1, 8'hA5, cur_cd, cur_m, 0, 0, 1, 3'd1);
    push(0, 0, 1, md,    cur_cd, cur_m, 0, 0, 1, 3'd2);
    push(0, 0, 1, b0,    cur_cd, cur_m, 0, 0, 1, 3'd3);
    push(0, 0, 1, b1,    cur_cd, cur_m, 0, 0, 1, 3'd4);
    push(0, 0, 1, b2,    cur_cd, cur_m, 0, 0, 1, 3'd5);
`ifdef FRAME_CHECKSUM_EN
    push(0, 0, 1, b3,    cur_cd, cur_m, 0, 0, 1, 3'd6);
    if (good) begin
      cur_cd = {b3, b2, b1, b0};
      cur_m  = md;
      push(0, 0, 1, md ^ b0 ^ b1 ^ b2 ^ b3, cur_cd, cur_m, 1, 0, 0, 3'd0);
    end else begin
      push(0, 0, 1, md ^ b0 ^ b1 ^ b2 ^ b3 ^ 8'h03, cur_cd, cur_m, 0, 1, 0, 3'd0);
    end
`else
    if (good) begin
      cur_cd = {b3, b2, b1, b0};
      cur_m  = md;
      push(0, 0, 1, b3, cur_cd, cur_m, 1, 0, 0, 3'd0);
    end
`endif
  endtask

  task automatic chkb(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic stepb(input logic c, input logic v, input logic [7:0] b);
    @(negedge clk);
    reset_b = 1'b0; cs_n_b = c; rx_rdy_b = v; rx_byte_b = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; cs_n = 1'b1; rx_rdy = 1'b0; rx_byte = 8'h00;
    reset_b = 1'b1; cs_n_b = 1'b1; rx_rdy_b = 1'b0; rx_byte_b = 8'h00;

    // Reset state
    push(1, 1, 0, 8'h00, 32'h0, 8'h00, 0, 0, 0, 3'd0);
    push(1, 1, 0, 8'h00, 32'h0, 8'h00, 0, 0, 0, 3'd0);
    push(0, 0, 0, 8'h00, 32'h0, 8'h00, 0, 0, 0, 3'd0);
    // Basic frame, then an idle cycle where frame_valid must drop
    frame(8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 1);
    push(0, 0, 0, 8'h00, cur_cd, cur_m, 0, 0, 0, 3'd0);
    // Partial frame aborted by cs_n
    push(0, 0, 1, 8'hA5, cur_cd, cur_m, 0, 0, 1, 3'd1);
    push(0, 0, 1, 8'h02, cur_cd, cur_m, 0, 0, 1, 3'd2);
    push(0, 0, 1, 8'h11, cur_cd, cur_m, 0, 0, 1, 3'd3);
    push(0, 0, 1, 8'h22, cur_cd, cur_m, 0, 0, 1, 3'd4);
    push(0, 1, 0, 8'h00, cur_cd, cur_m, 0, 1, 0, 3'd0);
    push(0, 1, 0, 8'h00, cur_cd, cur_m, 0, 0, 0, 3'd0);
    // Next full frame commits normally
    frame(8'h07, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 1);
    // Bad sync bytes in IDLE
    push(0, 0, 1, 8'h00, cur_cd, cur_m, 0, 1, 0, 3'd0);
    push(0, 0, 1, 8'hFF, cur_cd, cur_m, 0, 1, 0, 3'd0);
    push(0, 0, 0, 8'h00, cur_cd, cur_m, 0, 0, 0, 3'd0);
    // rx_rdy and cs_n high in the same cycle: abort wins
    push(0, 0, 1, 8'hA5, cur_cd, cur_m, 0, 0, 1, 3'd1);
    push(0, 1, 1, 8'h55, cur_cd, cur_m, 0, 1, 0, 3'd0);
    push(0, 0, 0, 8'h00, cur_cd, cur_m, 0, 0, 0, 3'd0);
`ifdef FRAME_CHECKSUM_EN
    // Checksum mismatch (0x42 instead of 0x41) discards the frame
    frame(8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 0);
`endif
    // Back-to-back frames, reset on the third byte of the second frame
    frame(8'h01, 8'h10, 8'h20, 8'h30, 8'h40, 1);
    push(0, 0, 1, 8'hA5, cur_cd, cur_m, 0, 0, 1, 3'd1);
    push(0, 0, 1, 8'h09, cur_cd, cur_m, 0, 0, 1, 3'd2);
    push(1, 0, 1, 8'h33, 32'h0, 8'h00, 0, 0, 0, 3'd0);
    push(0, 0, 0, 8'h00, 32'h0, 8'h00, 0, 0, 0, 3'd0);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      reset = vq[i].rst; cs_n = vq[i].cs; rx_rdy = vq[i].rdy; rx_byte = vq[i].b;
      @(posedge clk);
      #1;
      checks++;
      if ({ch_data, mode, frame_valid, frame_err, busy, byte_cnt} !==
          {vq[i].cd, vq[i].m, vq[i].fv, vq[i].fe, vq[i].bz, vq[i].cnt}) begin
        errors++;
        $display("FAIL vec%0d: got cd=%h m=%h fv=%b fe=%b busy=%b cnt=%0d, expected cd=%h m=%h fv=%b fe=%b busy=%b cnt=%0d",
                 i, ch_data, mode, frame_valid, frame_err, busy, byte_cnt,
                 vq[i].cd, vq[i].m, vq[i].fv, vq[i].fe, vq[i].bz, vq[i].cnt);
      end
    end

    // 16-bit channel instance: A5,03,12,34,56,78 -> ch_data 56781234
    stepb(1'b0, 1'b0, 8'h00);
    chkb("b_reset_cd", ch_data_b, 32'h0);
    stepb(1'b0, 1'b1, 8'hA5);
    chkb("b_sync_cnt_busy", {28'h0, busy_b, byte_cnt_b}, {28'h0, 1'b1, 3'd1});
    stepb(1'b0, 1'b1, 8'h03);
    stepb(1'b0, 1'b1, 8'h12);
    stepb(1'b0, 1'b1, 8'h34);
    stepb(1'b0, 1'b1, 8'h56);
    chkb("b_partial_cd", ch_data_b, 32'h0);
    stepb(1'b0, 1'b1, 8'h78);
`ifdef FRAME_CHECKSUM_EN
    chkb("b_csum_wait", {28'h0, frame_valid_b, byte_cnt_b}, {28'h0, 1'b0, 3'd6});
    stepb(1'b0, 1'b1, 8'h0B);
`endif
    chkb("b_commit_cd", ch_data_b, 32'h56781234);
    chkb("b_commit_mode_fv", {22'h0, mode_b, frame_valid_b, busy_b}, {22'h0, 8'h03, 1'b1, 1'b0});
    stepb(1'b0, 1'b0, 8'h00);
    chkb("b_fv_pulse_end", {31'h0, frame_valid_b}, 32'h0);
    chkb("b_hold_cd", ch_data_b, 32'h56781234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
